// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline WriteBack always wins, IO load results
// wait in an in-order queue, and a starvation timer asks the pipeline for a bubble.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     PipeValid,
  input  logic [ADDR_W-1:0]        PipeRd,
  input  logic [DATA_W-1:0]        PipeData,
  input  logic                     IOReqValid,
  input  logic [ADDR_W-1:0]        IOReqRd,
  input  logic [DATA_W-1:0]        IOReqData,
  output logic                     IOReqReady,
  output logic                     RfWe,
  output logic [ADDR_W-1:0]        RfAddr,
  output logic [DATA_W-1:0]        RfData,
  output logic                     StallReq,
  output logic [$clog2(DEPTH):0]   QCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [ADDR_W-1:0] rd_q  [DEPTH];
  logic [ADDR_W-1:0] rd_d  [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [DATA_W-1:0] dat_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              stall_q, stall_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic ready_s, xfer_s, empty_s, head_vld_s, head_sq_s, pop_s, push_s;

  // Port arbitration, queue update, squash and starvation tracking
  always_comb begin
    ready_s    = (cnt_q < DEPTH_C);
    xfer_s     = IOReqValid & ready_s;
    empty_s    = (cnt_q == CW'(0));
    head_vld_s = !empty_s && vld_q[head_q];
    head_sq_s  = head_vld_s && PipeValid && (rd_q[head_q] == PipeRd);
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    pop_s      = 1'b0;
    push_s     = 1'b0;

    if (PipeValid) begin
      we_d   = 1'b1;
      addr_d = PipeRd;
      data_d = PipeData;
      // a squashed head still drains, and a same-Rd IO result is older so it is dropped
      pop_s  = !empty_s && !vld_q[head_q];
      push_s = xfer_s && (IOReqRd != PipeRd);
    end else if (head_vld_s) begin
      we_d   = 1'b1;
      addr_d = rd_q[head_q];
      data_d = dat_q[head_q];
      pop_s  = 1'b1;
      push_s = xfer_s;
    end else if (!empty_s) begin
      pop_s  = 1'b1;
      push_s = xfer_s;
    end else if (xfer_s) begin
      we_d   = 1'b1;
      addr_d = IOReqRd;
      data_d = IOReqData;
    end else begin
      we_d   = 1'b0;
    end

    for (int i = 0; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i] & ~(PipeValid & (rd_q[i] == PipeRd));
      if (push_s && (tail_q == PW'(i))) begin
        vld_d[i] = 1'b1;
        rd_d[i]  = IOReqRd;
        dat_d[i] = IOReqData;
      end else begin
        rd_d[i]  = rd_q[i];
        dat_d[i] = dat_q[i];
      end
    end

    head_d = pop_s  ? head_q + PW'(1) : head_q;
    tail_d = push_s ? tail_q + PW'(1) : tail_q;

    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (pop_s || head_sq_s || !head_vld_s) begin
      starve_d = SW'(0);
    end else if (starve_q == STARVE_C) begin
      starve_d = starve_q;
    end else begin
      starve_d = starve_q + SW'(1);
    end
    stall_d = (starve_d == STARVE_C);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= rd_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign IOReqReady = ready_s;
  assign RfWe       = we_q;
  assign RfAddr     = addr_q;
  assign RfData     = data_q;
  assign StallReq   = stall_q;
  assign QCount     = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Table-driven bench for wb_port_arbiter with a scoreboard of expected register-file writes.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        PipeValid;
  logic [4:0]  PipeRd;
  logic [31:0] PipeData;
  logic        IOReqValid;
  logic [4:0]  IOReqRd;
  logic [31:0] IOReqData;
  logic        IOReqReady;
  logic        RfWe;
  logic [4:0]  RfAddr;
  logic [31:0] RfData;
  logic        StallReq;
  logic [2:0]  QCount;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .PipeValid(PipeValid), .PipeRd(PipeRd), .PipeData(PipeData),
    .IOReqValid(IOReqValid), .IOReqRd(IOReqRd), .IOReqData(IOReqData),
    .IOReqReady(IOReqReady),
    .RfWe(RfWe), .RfAddr(RfAddr), .RfData(RfData),
    .StallReq(StallReq), .QCount(QCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        iv;
    logic [4:0]  ird;
    logic [31:0] id;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [2:0]  eqc;
    logic        est;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic pv, logic [4:0] prd, logic [31:0] pd,
                              logic iv, logic [4:0] ird, logic [31:0] id,
                              logic ewe, logic [4:0] ea, logic [31:0] ed,
                              logic [2:0] eqc, logic est);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pd = pd;
    v.iv = iv; v.ird = ird; v.id = id;
    v.ewe = ewe; v.ea = ea; v.ed = ed; v.eqc = eqc; v.est = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every RfWe must match the oldest outstanding expected write
  task automatic mon_write();
    wr_t w;
    if (RfWe === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%0h, expected no write (t=%0t)",
                 RfAddr, RfData, $time);
      end else begin
        w = sb.pop_front();
        chk("wr_addr", 32'(RfAddr), 32'(w.a));
        chk("wr_data", RfData, w.d);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    wr_t w;
    PipeValid  = v.pv;  PipeRd  = v.prd; PipeData  = v.pd;
    IOReqValid = v.iv;  IOReqRd = v.ird; IOReqData = v.id;
    if (v.ewe) begin
      w.a = v.ea;
      w.d = v.ed;
      sb.push_back(w);
    end
    @(posedge clk);
    #1;
    mon_write();
    chk($sformatf("rfwe[%0d]", idx),   32'(RfWe),       32'(v.ewe));
    chk($sformatf("qcount[%0d]", idx), 32'(QCount),     32'(v.eqc));
    chk($sformatf("ready[%0d]", idx),  32'(IOReqReady), 32'(v.eqc < 3'd4));
    chk($sformatf("stall[%0d]", idx),  32'(StallReq),   32'(v.est));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rfwe"},  32'(RfWe),       32'd0);
    chk({tag, "_addr"},  32'(RfAddr),     32'd0);
    chk({tag, "_data"},  RfData,          32'd0);
    chk({tag, "_stall"}, 32'(StallReq),   32'd0);
    chk({tag, "_qcnt"},  32'(QCount),     32'd0);
    chk({tag, "_ready"}, 32'(IOReqReady), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    PipeValid = 1'b0; PipeRd = 5'd0; PipeData = 32'd0;
    IOReqValid = 1'b0; IOReqRd = 5'd0; IOReqData = 32'd0;

    //        pv    prd    pd            iv    ird    id            ewe   ea     ed            qc    st
    // idle bypass
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b1, 5'd7,  32'h55,     1'b1, 5'd7,  32'h55,     3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      3'd0, 1'b0));
    // contention: pipeline first, IO on the next cycle
    vecs.push_back(mk(1'b1, 5'd3,  32'h10,     1'b1, 5'd4,  32'h20,     1'b1, 5'd3,  32'h10,     3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 5'd4,  32'h20,     3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      3'd0, 1'b0));
    // WAW squash: IO Rd=9 queued, pipeline later writes Rd=9
    vecs.push_back(mk(1'b1, 5'd1,  32'h1,      1'b1, 5'd9,  32'h99,     1'b1, 5'd1,  32'h1,      3'd1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd2,  32'h2,      1'b0, 5'd0,  32'h0,      1'b1, 5'd2,  32'h2,      3'd1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd9,  32'hAA,     1'b0, 5'd0,  32'h0,      1'b1, 5'd9,  32'hAA,     3'd1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd5,  32'h5,      1'b0, 5'd0,  32'h0,      1'b1, 5'd5,  32'h5,      3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      3'd0, 1'b0));
    // full queue under a continuous pipeline stream; 5th IO is refused
    vecs.push_back(mk(1'b1, 5'd20, 32'h100,    1'b1, 5'd10, 32'hA0,     1'b1, 5'd20, 32'h100,    3'd1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd21, 32'h101,    1'b1, 5'd11, 32'hA1,     1'b1, 5'd21, 32'h101,    3'd2, 1'b0));
    vecs.push_back(mk(1'b1, 5'd22, 32'h102,    1'b1, 5'd12, 32'hA2,     1'b1, 5'd22, 32'h102,    3'd3, 1'b0));
    vecs.push_back(mk(1'b1, 5'd23, 32'h103,    1'b1, 5'd13, 32'hA3,     1'b1, 5'd23, 32'h103,    3'd4, 1'b1));
    vecs.push_back(mk(1'b1, 5'd24, 32'h104,    1'b1, 5'd14, 32'hA4,     1'b1, 5'd24, 32'h104,    3'd4, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 5'd10, 32'hA0,     3'd3, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 5'd11, 32'hA1,     3'd2, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 5'd12, 32'hA2,     3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 5'd13, 32'hA3,     3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      3'd0, 1'b0));
    // starvation: StallReq on the third edge after enqueue, cleared when the entry drains
    vecs.push_back(mk(1'b1, 5'd1,  32'h11,     1'b1, 5'd6,  32'h66,     1'b1, 5'd1,  32'h11,     3'd1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd2,  32'h22,     1'b0, 5'd0,  32'h0,      1'b1, 5'd2,  32'h22,     3'd1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd3,  32'h33,     1'b0, 5'd0,  32'h0,      1'b1, 5'd3,  32'h33,     3'd1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd4,  32'h44,     1'b0, 5'd0,  32'h0,      1'b1, 5'd4,  32'h44,     3'd1, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 5'd6,  32'h66,     3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      3'd0, 1'b0));
    // same-cycle IO with the pipeline's Rd is discarded; squashed head drains under PipeValid
    vecs.push_back(mk(1'b1, 5'd1,  32'h1,      1'b1, 5'd8,  32'h80,     1'b1, 5'd1,  32'h1,      3'd1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd8,  32'h88,     1'b1, 5'd8,  32'h81,     1'b1, 5'd8,  32'h88,     3'd1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd2,  32'h2,      1'b0, 5'd0,  32'h0,      1'b1, 5'd2,  32'h2,      3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      3'd0, 1'b0));
    // enqueue and pop in the same cycle
    vecs.push_back(mk(1'b1, 5'd1,  32'h1,      1'b1, 5'd14, 32'hE0,     1'b1, 5'd1,  32'h1,      3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b1, 5'd15, 32'hF0,     1'b1, 5'd14, 32'hE0,     3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 5'd15, 32'hF0,     3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      3'd0, 1'b0));

    #12;
    chk_reset_state("por");
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // reset with two IO entries queued: everything clears at once, no stale write afterwards
    run_vec(mk(1'b1, 5'd1, 32'h301, 1'b1, 5'd16, 32'hC0, 1'b1, 5'd1, 32'h301, 3'd1, 1'b0), 100);
    run_vec(mk(1'b1, 5'd2, 32'h302, 1'b1, 5'd17, 32'hC1, 1'b1, 5'd2, 32'h302, 3'd2, 1'b0), 101);
    PipeValid = 1'b0; IOReqValid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(posedge clk);
    #1;
    chk_reset_state("midrst_hold");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_vec(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0), 200 + i);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writers: the in-order pipeline WriteBack stage and the multi-cycle IO/peripheral load unit.
- Pipeline writes always win the port. IO results wait in a small in-order queue and drain into free slots.
- WAW conflicts resolve in favour of the pipeline.
- A starvation timer requests a one-slot pipeline bubble so that queued IO results cannot wait forever.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- DEPTH, 4, IO queue entries (power of 2, ≥2)
- STARVE_MAX, 3, cycles a valid head may wait before StallReq is raised

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- PipeValid  in  1  pipeline WB writes this cycle (RegWrite of WB stage)
- PipeRd  in  ADDR_W  pipeline destination register
- PipeData  in  DATA_W  pipeline result (post MemToReg mux)
- IOReqValid  in  1  IO unit presents a completed load
- IOReqRd  in  ADDR_W  IO destination register
- IOReqData  in  DATA_W  IO load data
- IOReqReady  out  1  queue can accept; transfer = IOReqValid & IOReqReady
- RfWe  out  1  register-file write enable (registered)
- RfAddr  out  ADDR_W  register-file write address (registered)
- RfData  out  DATA_W  register-file write data (registered)
- StallReq  out  1  pipeline must present PipeValid=0 next cycle
- QCount  out  $clog2(DEPTH)+1  occupied queue entries, including squashed entries

Behaviour:
- Reset (rst=0, asynchronous): RfWe=0, RfAddr=0, RfData=0, StallReq=0, queue empty, QCount=0, starve counter=0.
- IOReqReady = (QCount < DEPTH), computed from registered state only. The same cycle's pop does not raise it.
- Each queue entry holds {valid, Rd, data}. FIFO order is fixed.
- Per-cycle priority, evaluated at the rising edge:
  1. PipeValid=1: RfWe<=1, RfAddr<=PipeRd, RfData<=PipeData.
     - Every queued entry with Rd==PipeRd gets valid<=0 (squash; the IO result is older in program order).
     - An IO transfer accepted this cycle with IOReqRd==PipeRd is accepted but discarded and not enqueued.
  2. Else, if the queue head is valid: the head pops, and RfWe/RfAddr/RfData<=head.
  3. Else, if the queue is empty and an IO transfer occurs: bypass. RfWe<=1 with the IO Rd/data, nothing enqueued.
  4. Else RfWe<=0, and RfAddr/RfData hold their previous value.
- Squashed (invalid) heads pop every cycle without a write, even when PipeValid=1.
- Otherwise an IO transfer that is not bypassed or discarded enqueues at the tail. Enqueue and pop may occur in the same cycle.
- Latency:
  - Pipeline write: 1 cycle.
  - IO write, idle port: 1 cycle.
  - IO write, queued: the first free slot after all older entries.
- Starve counter:
  - Increments each cycle a valid head exists and does not pop; saturates at STARVE_MAX.
  - Clears on head pop or squash.
- StallReq<=1 when the counter reaches STARVE_MAX. It holds until the head pops, then clears on the edge after that pop.
- If the pipeline ignores StallReq, the pipeline still wins. No write is ever lost or duplicated.
- QCount is the registered count: +1 on enqueue, −1 on pop, unchanged when both occur in the same cycle.
- Mid-operation reset discards all queued entries. No partial write is issued.

Test Plan:
- Reset mid-queue: QCount=2 at rst=0 → RfWe=0 and QCount=0 immediately; after release, no stale write occurs.
- Idle bypass: PipeValid=0, IOReqValid=1, Rd=7, data=0x55 → next cycle RfWe=1, RfAddr=7, RfData=0x55, QCount=0.
- Contention: PipeValid=1 (Rd=3, 0x10) and IO (Rd=4, 0x20) in the same cycle; PipeValid=0 the next cycle → writes (3,0x10) then (4,0x20) on consecutive cycles.
- WAW squash:
  - Setup: queue IO Rd=9 behind a continuous pipeline stream, then pipeline writes Rd=9 (0xAA).
  - Required: the Rd=9 IO entry is never written; QCount drops by 1 in a later cycle without RfWe for Rd=9.
- Full queue: 4 IO transfers while PipeValid=1 every cycle (distinct Rds) → IOReqReady=0 at QCount=4; a 5th IOReqValid is not accepted; after PipeValid drops, 4 drains occur in FIFO order.
- Starvation: PipeValid held at 1 with 1 valid entry → StallReq=1 on the third cycle after enqueue; bench drops PipeValid for one cycle → entry written, StallReq=0 on the next edge.
